// File: rtl/alu_shift_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_shift_sequencer_pkg
// Description : Shared definitions for the multi-cycle shift sequencer:
//               ALU operation codes (shared with the ALU_nbit control
//               decode), sequencer state encodings, and a helper that
//               classifies an op code as one of the single-bit shift ops.
// Contents    : ALU_* op codes (4 bits), seq_state_t (2 bits),
//               is_shift_op()
// Revision    : 1.0 - initial release
// ============================================================================
package alu_shift_sequencer_pkg;

    // ALU control codes; must agree with the ALU_nbit decode.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    // True for the ops the ALU implements as a single-bit shift.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage : alu_shift_sequencer_pkg
`default_nettype wire

// File: rtl/alu_shift_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_shift_sequencer
// Description : Multi-cycle controller that builds RV32I variable-amount
//               shifts (shamt 0..N-1) out of the ALU's shift-by-one ops.
//               While busy it owns the ALU A operand and alu_control and
//               feeds the ALU result back into its work register, one bit
//               position per cycle. Non-shift ops and shamt==0 complete in
//               a single cycle as a pass-through of the operand.
// Ports       : clk, rst        - clock (rising edge), sync active-high reset
//               start, ready    - request / accept handshake (start & ready)
//               op, operand,
//               shamt           - request payload, sampled only at accept
//               busy            - shift iteration in progress (stall)
//               done, result    - one-cycle completion pulse / held result
//               alu_a, alu_ctrl - drive the external ALU
//               alu_result      - combinational ALU output, same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int N       = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [N-1:0]       operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       result,
    output logic [N-1:0]       alu_a,
    output logic [3:0]         alu_ctrl,
    input  logic [N-1:0]       alu_result
);

    seq_state_t         r_state;
    logic [3:0]         r_op;
    logic [N-1:0]       r_work;
    logic [SHAMT_W-1:0] r_count;
    logic [N-1:0]       r_result;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [3:0]         r_alu_ctrl;

    // A request is taken only from IDLE or DONE; reset has priority
    // because it is handled first in the sequential block.
    logic w_accept;
    logic w_needs_shift;

    assign w_accept      = start && r_ready;
    assign w_needs_shift = is_shift_op(op) && (shamt != '0);

    // Single FSM; every output is registered alongside the state so the
    // ALU control and handshake flags change only on clock edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= ALU_PASS;
            r_work     <= '0;
            r_count    <= '0;
            r_result   <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_alu_ctrl <= ALU_PASS;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_work  <= operand;
                        r_count <= shamt;
                        if (w_needs_shift) begin
                            r_state    <= ST_SHIFT;
                            r_ready    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_alu_ctrl <= op;
                        end else begin
                            // Zero-length or non-shift request: the
                            // operand itself is the answer.
                            r_state    <= ST_DONE;
                            r_result   <= operand;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_alu_ctrl <= ALU_PASS;
                        end
                    end else begin
                        r_state    <= ST_IDLE;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b0;
                        r_alu_ctrl <= ALU_PASS;
                    end
                end

                ST_SHIFT: begin
                    // The ALU is shifting r_work by one this cycle.
                    r_work  <= alu_result;
                    r_count <= r_count - SHAMT_W'(1);
                    if (r_count == SHAMT_W'(1)) begin
                        r_state    <= ST_DONE;
                        r_result   <= alu_result;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_alu_ctrl <= ALU_PASS;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_ready    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_alu_ctrl <= ALU_PASS;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign alu_a    = r_work;
    assign alu_ctrl = r_alu_ctrl;

endmodule : alu_shift_sequencer
`default_nettype wire

// File: tb/tb_alu_shift_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_shift_sequencer
// Description : Self-checking bench for alu_shift_sequencer. Includes a
//               behavioural single-bit-shift ALU standing in for ALU_nbit,
//               and a reference model that computes the full shift result
//               and start->done latency directly from op/operand/shamt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_sequencer;
    import alu_shift_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_shift_sequencer #(.N(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .operand    (operand),
        .shamt      (shamt),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_a      (alu_a),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    // Stand-in for the external ALU: shift ops move one bit position.
    always_comb begin
        alu_result = alu_a;
        case (alu_ctrl)
            ALU_SLL: alu_result = alu_a << 1;
            ALU_SRL: alu_result = alu_a >> 1;
            ALU_SRA: alu_result = {alu_a[31], alu_a[31:1]};
            default: alu_result = alu_a;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: full-width shift by shamt in one step.
    function automatic logic [31:0] ref_result(input logic [3:0] xop, input logic [31:0] xa,
                                               input logic [4:0] xsh);
        case (xop)
            ALU_SLL: return xa << xsh;
            ALU_SRL: return xa >> xsh;
            ALU_SRA: return $unsigned($signed(xa) >>> xsh);
            default: return xa;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] xop, input logic [4:0] xsh);
        if ((xop == ALU_SLL || xop == ALU_SRL || xop == ALU_SRA) && xsh != 5'd0)
            return int'(xsh) + 1;
        return 1;
    endfunction

    // Issue one request and follow it to its done pulse. Request inputs are
    // scrambled after accept; with poke set, stray start pulses carrying
    // garbage are thrown in while the sequencer is busy.
    task automatic run_op(input logic [3:0] xop, input logic [31:0] xa, input logic [4:0] xsh,
                          input bit poke);
        int lat;
        @(negedge clk);
        start   = 1'b1;
        op      = xop;
        operand = xa;
        shamt   = xsh;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 4'($urandom);
        operand = $urandom;
        shamt   = 5'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin
            check_val("busy_high", {31'd0, busy}, 32'd1);
            check_val("ready_low", {31'd0, ready}, 32'd0);
            check_val("alu_ctrl_shift", {28'd0, alu_ctrl}, {28'd0, xop});
            start   = poke && ($urandom_range(0, 1) == 1);
            op      = 4'($urandom);
            operand = $urandom;
            shamt   = 5'($urandom);
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        check_val("latency", 32'(lat), 32'(ref_latency(xop, xsh)));
        check_val("result", result, ref_result(xop, xa, xsh));
        check_val("done_ready", {31'd0, ready}, 32'd1);
        check_val("done_busy", {31'd0, busy}, 32'd0);
        check_val("alu_ctrl_pass", {28'd0, alu_ctrl}, {28'd0, ALU_PASS});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic [3:0] rop;
        logic [4:0] rsh;
        int gap;

        rst     = 1'b1;
        start   = 1'b0;
        op      = ALU_ADD;
        operand = '0;
        shamt   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", {31'd0, ready}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_alu_a", alu_a, 32'd0);
        check_val("rst_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_PASS});
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(ALU_SLL, 32'h0000_0001, 5'd4, 1'b0);
        check_val("sll_1_by_4", result, 32'h0000_0010);
        run_op(ALU_SRA, 32'h8000_0000, 5'd31, 1'b0);
        check_val("sra_msb_by_31", result, 32'hFFFF_FFFF);
        run_op(ALU_SRL, 32'h8000_0000, 5'd31, 1'b0);
        check_val("srl_msb_by_31", result, 32'h0000_0001);
        run_op(ALU_SRL, 32'hDEAD_BEEF, 5'd0, 1'b0);
        run_op(ALU_ADD, 32'hDEAD_BEEF, 5'd17, 1'b0);
        run_op(ALU_SLL, 32'h0000_1234, 5'd8, 1'b1);
        run_op(ALU_SLL, 32'h0000_0001, 5'd1, 1'b0);
        check_val("b2b_first", result, 32'h0000_0002);
        run_op(ALU_SRL, 32'h0000_0008, 5'd3, 1'b0);
        check_val("b2b_second", result, 32'h0000_0001);

        // DONE falls back to IDLE when no new request arrives.
        @(posedge clk);
        #1;
        check_val("idle_done_low", {31'd0, done}, 32'd0);
        check_val("idle_ready", {31'd0, ready}, 32'd1);

        // Reset after three SHIFT cycles of SLL by 10.
        @(negedge clk);
        start = 1'b1; op = ALU_SLL; operand = 32'h1; shamt = 5'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_ready", {31'd0, ready}, 32'd1);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check_val("midrst_no_done", 32'(pulses), 32'd0);

        // Reset and start together: the request is dropped.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = ALU_SRL; operand = 32'hF0; shamt = 5'd3;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check_val("rst_start_dropped", 32'(pulses), 32'd0);
        check_val("rst_start_result", result, 32'd0);

        // Randomized requests, mixed back-to-back and with idle gaps.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: rop = ALU_SLL;
                1: rop = ALU_SRL;
                2: rop = ALU_SRA;
                3: rop = ALU_ADD;
                4: rop = ALU_PASS;
                default: rop = 4'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: rsh = 5'd0;
                1: rsh = 5'd31;
                default: rsh = 5'($urandom);
            endcase
            run_op(rop, $urandom, rsh, ($urandom_range(0, 3) == 0));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(posedge clk);
                #1;
                check_val("rand_gap_done", {31'd0, done}, 32'd0);
                check_val("rand_gap_ready", {31'd0, ready}, 32'd1);
                repeat (gap - 1) @(posedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_shift_sequencer
`default_nettype wire
